alarm_fsm: RTL and testbench

Central control state machine of the car anti-theft system. It consumes the debounced door, ignition and reprogram inputs and the `expired` / `one_hz_enable` strobes from the timer. It drives the timer handshake (`start_timer`, `interval_sel`), the siren generator enable and the status LED. It also exports its state code for the seven-segment display.

---
 rtl/alarm_pkg.sv | 23 ++
 rtl/alarm_fsm_if.sv | 28 ++
 rtl/alarm_fsm.sv | 115 +++++++++++
 tb/tb_alarm_fsm.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared constants for the anti-theft controller: state codes and timer interval codes.
// The display decoder and the testbench import this package as well.
package alarm_pkg;

    typedef enum logic [2:0] {
        StArmed         = 3'd0,
        StTriggered     = 3'd1,
        StSoundAlarm    = 3'd2,
        StAlarmHold     = 3'd3,
        StDisarmed      = 3'd4,
        StWaitDoorOpen  = 3'd5,
        StWaitDoorClose = 3'd6,
        StArmDelay      = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        IntArmDelay       = 2'b00,
        IntDriverDelay    = 2'b01,
        IntPassengerDelay = 2'b10,
        IntAlarmOn        = 2'b11
    } interval_t;

endpackage

// File: rtl/alarm_fsm_if.sv
// Signal bundle between the alarm controller and its environment (debouncers, timer,
// siren, LED, display). The slave modport is the controller's view.
interface alarm_fsm_if;
    import alarm_pkg::*;

    logic       ignition;
    logic       door_driver;
    logic       door_pass;
    logic       reprogram;
    logic       expired;
    logic       one_hz_enable;
    logic       start_timer;
    logic [1:0] interval_sel;
    logic       enable_siren;
    logic       status;
    logic [2:0] estado;

    modport master (
        output ignition, door_driver, door_pass, reprogram, expired, one_hz_enable,
        input  start_timer, interval_sel, enable_siren, status, estado
    );

    modport slave (
        input  ignition, door_driver, door_pass, reprogram, expired, one_hz_enable,
        output start_timer, interval_sel, enable_siren, status, estado
    );

endinterface

// File: rtl/alarm_fsm.sv
// Central control state machine of the car anti-theft system. Every output is a register;
// the next-state logic decides the new state and the values the outputs take with it.
module alarm_fsm
    import alarm_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    alarm_fsm_if.slave   bus
);

    state_t    state_q, state_d;
    interval_t interval_q, interval_d;
    logic      start_q, start_d;
    logic      status_q, status_d;
    logic      siren_q, siren_d;
    logic      any_door;
    logic      expired_ok;

    assign any_door   = bus.door_driver | bus.door_pass;
    // The cycle that loads the timer cannot also see it expire.
    assign expired_ok = bus.expired & ~start_q;

    // Next state, timer request and output values, with reprogram > ignition > doors > expired.
    always_comb begin
        state_d    = state_q;
        interval_d = interval_q;
        start_d    = 1'b0;

        if (bus.reprogram) begin
            state_d = StArmed;
        end else if (bus.ignition && state_q != StDisarmed) begin
            state_d = StDisarmed;
        end else begin
            unique case (state_q)
                StArmed: begin
                    if (bus.door_driver) begin
                        state_d    = StTriggered;
                        interval_d = IntDriverDelay;
                        start_d    = 1'b1;
                    end else if (bus.door_pass) begin
                        state_d    = StTriggered;
                        interval_d = IntPassengerDelay;
                        start_d    = 1'b1;
                    end
                end
                StTriggered: begin
                    if (expired_ok) state_d = StSoundAlarm;
                end
                StSoundAlarm: begin
                    if (!any_door) begin
                        state_d    = StAlarmHold;
                        interval_d = IntAlarmOn;
                        start_d    = 1'b1;
                    end
                end
                StAlarmHold: begin
                    if (any_door)        state_d = StSoundAlarm;
                    else if (expired_ok) state_d = StArmed;
                end
                StDisarmed: begin
                    if (!bus.ignition) state_d = StWaitDoorOpen;
                end
                StWaitDoorOpen: begin
                    if (bus.door_driver) state_d = StWaitDoorClose;
                end
                StWaitDoorClose: begin
                    if (!any_door) begin
                        state_d    = StArmDelay;
                        interval_d = IntArmDelay;
                        start_d    = 1'b1;
                    end
                end
                StArmDelay: begin
                    if (any_door)        state_d = StWaitDoorClose;
                    else if (expired_ok) state_d = StArmed;
                end
                default: state_d = StArmed;
            endcase
        end

        unique case (state_d)
            // Entering ARMED starts the blink from 0; staying in ARMED toggles on the strobe.
            StArmed:                              status_d = (state_q == StArmed) ?
                                                             (status_q ^ bus.one_hz_enable) : 1'b0;
            StTriggered, StSoundAlarm, StAlarmHold: status_d = 1'b1;
            default:                              status_d = 1'b0;
        endcase

        siren_d = (state_d == StSoundAlarm) || (state_d == StAlarmHold);
    end

    // State and output registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StArmed;
            interval_q <= IntArmDelay;
            start_q    <= 1'b0;
            status_q   <= 1'b0;
            siren_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            interval_q <= interval_d;
            start_q    <= start_d;
            status_q   <= status_d;
            siren_q    <= siren_d;
        end
    end

    assign bus.start_timer  = start_q;
    assign bus.interval_sel = interval_q;
    assign bus.enable_siren = siren_q;
    assign bus.status       = status_q;
    assign bus.estado       = state_q;

endmodule

// File: tb/tb_alarm_fsm.sv
// Directed self-checking bench for alarm_fsm; expected values are hand-computed per step.
module tb_alarm_fsm;
    import alarm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    alarm_fsm_if bus ();

    alarm_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.ignition = 0; bus.door_driver = 0; bus.door_pass = 0;
        bus.reprogram = 0; bus.expired = 0; bus.one_hz_enable = 0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_estado", bus.estado, 3'd0);
        chk("rst_status", {2'b0, bus.status}, 3'd0);
        chk("rst_siren", {2'b0, bus.enable_siren}, 3'd0);
        chk("rst_start", {2'b0, bus.start_timer}, 3'd0);
        chk("rst_isel", {1'b0, bus.interval_sel}, 3'd0);

        // Blink in ARMED: 1, 0, 1
        bus.one_hz_enable = 1; tick(); bus.one_hz_enable = 0;
        chk("blink1", {2'b0, bus.status}, 3'd1);
        tick();
        chk("blink_hold", {2'b0, bus.status}, 3'd1);
        bus.one_hz_enable = 1; tick(); bus.one_hz_enable = 0;
        chk("blink2", {2'b0, bus.status}, 3'd0);
        bus.one_hz_enable = 1; tick(); bus.one_hz_enable = 0;
        chk("blink3", {2'b0, bus.status}, 3'd1);
        chk("blink_estado", bus.estado, 3'd0);
        chk("blink_siren", {2'b0, bus.enable_siren}, 3'd0);

        // Passenger door triggers
        bus.door_pass = 1; tick();
        chk("trig_estado", bus.estado, 3'd1);
        chk("trig_status", {2'b0, bus.status}, 3'd1);
        chk("trig_start", {2'b0, bus.start_timer}, 3'd1);
        chk("trig_isel", {1'b0, bus.interval_sel}, 3'd2);
        // expired in the start cycle is ignored; door activity ignored too
        bus.expired = 1; tick(); bus.expired = 0;
        chk("trig_ign_exp", bus.estado, 3'd1);
        chk("trig_start_once", {2'b0, bus.start_timer}, 3'd0);
        chk("trig_isel_hold", {1'b0, bus.interval_sel}, 3'd2);
        bus.expired = 1; tick(); bus.expired = 0;
        chk("sound_estado", bus.estado, 3'd2);
        chk("sound_siren", {2'b0, bus.enable_siren}, 3'd1);

        // Close doors -> ALARM_HOLD
        bus.door_pass = 0; tick();
        chk("hold_estado", bus.estado, 3'd3);
        chk("hold_start", {2'b0, bus.start_timer}, 3'd1);
        chk("hold_isel", {1'b0, bus.interval_sel}, 3'd3);
        tick();
        chk("hold_start_off", {2'b0, bus.start_timer}, 3'd0);
        bus.door_driver = 1; tick();
        chk("reopen_estado", bus.estado, 3'd2);
        chk("reopen_siren", {2'b0, bus.enable_siren}, 3'd1);
        bus.door_driver = 0; tick();
        chk("reclose_estado", bus.estado, 3'd3);
        tick();
        bus.expired = 1; tick(); bus.expired = 0;
        chk("rearm_estado", bus.estado, 3'd0);
        chk("rearm_siren", {2'b0, bus.enable_siren}, 3'd0);
        chk("rearm_status", {2'b0, bus.status}, 3'd0);
        bus.expired = 1; tick(); bus.expired = 0;
        chk("stray_expired", bus.estado, 3'd0);

        // Arming sequence
        bus.door_driver = 1; tick(); bus.door_driver = 0;
        chk("drv_trig_isel", {1'b0, bus.interval_sel}, 3'd1);
        bus.ignition = 1; tick();
        chk("ign_estado", bus.estado, 3'd4);
        chk("ign_status", {2'b0, bus.status}, 3'd0);
        tick();
        chk("ign_stay", bus.estado, 3'd4);
        bus.ignition = 0; tick();
        chk("wait_open", bus.estado, 3'd5);
        bus.door_driver = 1; tick();
        chk("wait_close", bus.estado, 3'd6);
        bus.door_driver = 0; tick();
        chk("armdly_estado", bus.estado, 3'd7);
        chk("armdly_isel", {1'b0, bus.interval_sel}, 3'd0);
        chk("armdly_start", {2'b0, bus.start_timer}, 3'd1);
        bus.door_pass = 1; tick();
        chk("armdly_reopen", bus.estado, 3'd6);
        bus.door_pass = 0; tick();
        chk("armdly_again", bus.estado, 3'd7);
        tick();
        bus.expired = 1; tick(); bus.expired = 0;
        chk("armed_again", bus.estado, 3'd0);

        // Both doors at once: driver interval wins
        bus.door_driver = 1; bus.door_pass = 1; tick();
        bus.door_driver = 0; bus.door_pass = 0;
        chk("both_estado", bus.estado, 3'd1);
        chk("both_isel", {1'b0, bus.interval_sel}, 3'd1);
        tick();
        bus.expired = 1; bus.ignition = 1; tick();
        bus.expired = 0; bus.ignition = 0;
        chk("ign_over_exp", bus.estado, 3'd4);
        chk("ign_no_siren", {2'b0, bus.enable_siren}, 3'd0);
        tick();
        chk("to_wait_open", bus.estado, 3'd5);

        // Reprogram held: ARMED, no start, blink continues
        bus.reprogram = 1; tick();
        chk("reprog_estado", bus.estado, 3'd0);
        chk("reprog_status", {2'b0, bus.status}, 3'd0);
        bus.door_pass = 1; tick();
        chk("reprog_hold", bus.estado, 3'd0);
        chk("reprog_nostart", {2'b0, bus.start_timer}, 3'd0);
        bus.one_hz_enable = 1; tick(); bus.one_hz_enable = 0;
        chk("reprog_blink", {2'b0, bus.status}, 3'd1);
        bus.reprogram = 0; bus.door_pass = 0;

        // Reprogram from ALARM_HOLD
        bus.door_pass = 1; tick(); bus.door_pass = 0;
        chk("t2_trig", bus.estado, 3'd1);
        tick();
        bus.expired = 1; tick(); bus.expired = 0;
        chk("t2_sound", bus.estado, 3'd2);
        tick();
        chk("t2_hold", bus.estado, 3'd3);
        bus.reprogram = 1; tick(); bus.reprogram = 0;
        chk("hold_reprog_estado", bus.estado, 3'd0);
        chk("hold_reprog_siren", {2'b0, bus.enable_siren}, 3'd0);
        chk("hold_reprog_status", {2'b0, bus.status}, 3'd0);

        // Synchronous reset during SOUND_ALARM
        bus.door_driver = 1; tick();
        tick();
        bus.expired = 1; tick(); bus.expired = 0;
        chk("t3_sound", bus.estado, 3'd2);
        reset = 1; tick(); reset = 0;
        chk("mid_rst_estado", bus.estado, 3'd0);
        chk("mid_rst_siren", {2'b0, bus.enable_siren}, 3'd0);
        chk("mid_rst_status", {2'b0, bus.status}, 3'd0);
        chk("mid_rst_start", {2'b0, bus.start_timer}, 3'd0);
        chk("mid_rst_isel", {1'b0, bus.interval_sel}, 3'd0);
        bus.door_driver = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
